// File: rtl/serial_add_pkg.sv
// Shared state encodings for the bit-serial add/subtract controller.
package serial_add_pkg;

   localparam logic [1:0] SA_IDLE = 2'd0;
   localparam logic [1:0] SA_RUN  = 2'd1;
   localparam logic [1:0] SA_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = SA_IDLE,
      RUN  = SA_RUN,
      DONE = SA_DONE
   } sa_state_t;

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder from two half adders; either half can raise the carry.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic w_s0;
   logic w_c0;
   logic w_c1;

   half_adder u_ha0 (
      .a     (a),
      .b     (b),
      .sum   (w_s0),
      .carry (w_c0)
   );

   half_adder u_ha1 (
      .a     (w_s0),
      .b     (cin),
      .sum   (sum),
      .carry (w_c1)
   );

   assign cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// 1-bit half adder cell.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice, LSB first,
// valid/ready on both the operation and result sides.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         op_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         carry_out,
   output logic         overflow,
   output logic         busy
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   sa_state_t r_state;
   sa_state_t w_next;

   logic [W-1:0]  r_a_sr;
   logic [W-1:0]  r_b_sr;
   logic          r_carry;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_sum;
   logic          r_carry_out;
   logic          r_overflow;

   logic w_fa_sum;
   logic w_fa_cout;
   logic w_accept;
   logic w_last;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_last   = (r_cnt == LAST);

   full_adder u_fa (
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .cin  (r_carry),
      .sum  (w_fa_sum),
      .cout (w_fa_cout)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_next = RUN;
         RUN:     if (w_last)    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default:                w_next = IDLE;
      endcase
   end

   // Operand load on accept, then one slice step per clock while running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_sr      <= '0;
         r_b_sr      <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_sum       <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (w_accept) begin
         r_a_sr  <= op_a;
         r_b_sr  <= op_sub ? ~op_b : op_b;
         r_carry <= op_sub;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_a_sr  <= r_a_sr >> 1;
         r_b_sr  <= r_b_sr >> 1;
         r_sum   <= (r_sum >> 1) | (W'(w_fa_sum) << (W - 1));
         r_carry <= w_fa_cout;
         r_cnt   <= r_cnt + CW'(1);
         if (w_last) begin
            r_overflow  <= r_carry ^ w_fa_cout;
            r_carry_out <= w_fa_cout;
         end
      end
   end

   // Handshake and status straight from the state register.
   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == RUN);

   assign sum       = r_sum;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at W=8 and W=1.
module tb_serial_add_ctrl;

   typedef struct {
      logic [63:0] s;
      bit          co;
      bit          ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;

   logic       in_valid8, in_ready8, op_sub8, out_valid8, out_ready8;
   logic       carry_out8, overflow8, busy8;
   logic [7:0] op_a8, op_b8, sum8;

   logic       in_valid1, in_ready1, op_sub1, out_valid1, out_ready1;
   logic       carry_out1, overflow1, busy1;
   logic [0:0] op_a1, op_b1, sum1;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q8[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   serial_add_ctrl #(.W(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .op_a(op_a8), .op_b(op_b8), .op_sub(op_sub8), .out_valid(out_valid8),
      .out_ready(out_ready8), .sum(sum8), .carry_out(carry_out8),
      .overflow(overflow8), .busy(busy8)
   );

   serial_add_ctrl #(.W(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .op_a(op_a1), .op_b(op_b1), .op_sub(op_sub1), .out_valid(out_valid1),
      .out_ready(out_ready1), .sum(sum1), .carry_out(carry_out1),
      .overflow(overflow1), .busy(busy1)
   );

   // Count one comparison and report a mismatch.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic: wide add with two's-complement subtract, sign-rule overflow.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input bit sub);
      exp_t        e;
      logic [64:0] mask, aa, bb, tot;
      bit          sa, sb, ss;
      mask = (65'd1 << w) - 65'd1;
      aa   = {1'b0, a} & mask;
      bb   = sub ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
      tot  = aa + bb + 65'(sub);
      e.s  = tot[63:0] & mask[63:0];
      e.co = tot[w];
      sa   = a[w-1];
      sb   = b[w-1];
      ss   = e.s[w-1];
      e.ov = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one W=8 op, wait for the result, compare against the scoreboard.
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input bit sub, input bit noisy);
      exp_t e;
      int   n;
      check("in_ready_idle8", 64'(in_ready8), 64'd1);
      q8.push_back(model(8, 64'(a), 64'(b), sub));
      op_a8 = a; op_b8 = b; op_sub8 = sub; in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      check("busy_run8", 64'(busy8), 64'd1);
      n = 0;
      while (!out_valid8 && n < 64) begin
         if (noisy) begin
            op_a8 = 8'($urandom); op_b8 = 8'($urandom);
            op_sub8 = 1'($urandom); in_valid8 = 1'($urandom);
         end
         step();
         n++;
      end
      in_valid8 = 1'b0;
      check("latency8", 64'(n), 64'd8);
      e = q8.pop_front();
      check("sum8", 64'(sum8), e.s);
      check("carry8", 64'(carry_out8), 64'(e.co));
      check("ovf8", 64'(overflow8), 64'(e.ov));
   endtask

   // Issue one W=1 op and compare.
   task automatic run_op1(input logic a, input logic b, input bit sub);
      exp_t e;
      int   n;
      check("in_ready_idle1", 64'(in_ready1), 64'd1);
      q1.push_back(model(1, 64'(a), 64'(b), sub));
      op_a1 = a; op_b1 = b; op_sub1 = sub; in_valid1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 16) begin
         step();
         n++;
      end
      check("latency1", 64'(n), 64'd1);
      e = q1.pop_front();
      check("sum1", 64'(sum1), e.s);
      check("carry1", 64'(carry_out1), 64'(e.co));
      check("ovf1", 64'(overflow1), 64'(e.ov));
      step();
      check("back_idle1", 64'(in_ready1), 64'd1);
   endtask

   initial begin
      exp_t e;
      rst = 1'b1;
      in_valid8 = 1'b0; op_a8 = '0; op_b8 = '0; op_sub8 = 1'b0; out_ready8 = 1'b1;
      in_valid1 = 1'b0; op_a1 = '0; op_b1 = '0; op_sub1 = 1'b0; out_ready1 = 1'b1;
      #12;
      check("rst_in_ready", 64'(in_ready8), 64'd1);
      check("rst_out_valid", 64'(out_valid8), 64'd0);
      check("rst_busy", 64'(busy8), 64'd0);
      check("rst_sum", 64'(sum8), 64'd0);
      check("rst_flags", 64'({carry_out8, overflow8}), 64'd0);
      check("rst_in_ready1", 64'(in_ready1), 64'd1);
      rst = 1'b0;
      step();

      // Basic adds and subtracts, result drained immediately.
      run_op8(8'h0F, 8'h01, 1'b0, 1'b0); step(); check("back_idle8", 64'(in_ready8), 64'd1);
      run_op8(8'hFF, 8'h01, 1'b0, 1'b0); step(); check("back_idle8", 64'(in_ready8), 64'd1);
      run_op8(8'h7F, 8'h01, 1'b0, 1'b0); step(); check("back_idle8", 64'(in_ready8), 64'd1);
      run_op8(8'h05, 8'h07, 1'b1, 1'b0); step(); check("back_idle8", 64'(in_ready8), 64'd1);
      run_op8(8'h80, 8'h01, 1'b1, 1'b0); step(); check("back_idle8", 64'(in_ready8), 64'd1);
      for (int i = 0; i < 6; i++) begin
         run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
         step();
         check("back_idle8", 64'(in_ready8), 64'd1);
      end

      // Backpressure with input noise during RUN and DONE.
      out_ready8 = 1'b0;
      run_op8(8'h3C, 8'hC5, 1'b0, 1'b1);
      e = model(8, 64'h3C, 64'hC5, 1'b0);
      for (int i = 0; i < 20; i++) begin
         in_valid8 = 1'(i); op_a8 = 8'($urandom); op_sub8 = 1'($urandom);
         step();
         check("bp_valid", 64'(out_valid8), 64'd1);
         check("bp_ready", 64'(in_ready8), 64'd0);
         check("bp_sum", 64'(sum8), e.s);
         check("bp_flags", 64'({carry_out8, overflow8}), 64'({e.co, e.ov}));
      end
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      step();
      check("bp_release_ready", 64'(in_ready8), 64'd1);
      check("bp_release_valid", 64'(out_valid8), 64'd0);
      step();
      check("bp_no_second_op", 64'(busy8), 64'd0);

      // Asynchronous reset in the middle of RUN.
      q8.push_back(model(8, 64'h55, 64'hAA, 1'b0));
      op_a8 = 8'h55; op_b8 = 8'hAA; op_sub8 = 1'b0; in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      step(); step(); step();
      check("mid_run_busy", 64'(busy8), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_in_ready", 64'(in_ready8), 64'd1);
      check("arst_out_valid", 64'(out_valid8), 64'd0);
      check("arst_busy", 64'(busy8), 64'd0);
      check("arst_sum", 64'(sum8), 64'd0);
      check("arst_flags", 64'({carry_out8, overflow8}), 64'd0);
      void'(q8.pop_back());
      step();
      rst = 1'b0;
      #1;
      run_op8(8'h01, 8'h01, 1'b0, 1'b0);
      step();

      // Single-bit build.
      run_op1(1'b1, 1'b1, 1'b0);
      run_op1(1'b1, 1'b1, 1'b1);
      run_op1(1'b0, 1'b1, 1'b1);
      run_op1(1'b1, 1'b0, 1'b0);

      check("sb_drained", 64'(q8.size() + q1.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
